// File: rtl/mmu_tlb.sv
// Dual-channel MIPS address translation: fixed kseg0/kseg1 mapping plus a fully-associative TLB
// with CP0 maintenance ops. Optional build macro MMU_K0_CFG_EN makes kseg0 cacheability follow k0_cca.
module mmu_tlb #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int ASID_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [31:0]           inst_vaddr,
    output logic                  inst_rvalid,
    output logic [31:0]           inst_paddr,
    output logic                  inst_uncached,
    output logic                  inst_refill,
    output logic                  inst_invalid,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [31:0]           data_vaddr,
    output logic                  data_rvalid,
    output logic [31:0]           data_paddr,
    output logic                  no_dcache,
    output logic                  data_refill,
    output logic                  data_invalid,
    output logic                  data_modified,
    input  logic [ASID_W-1:0]     cp0_asid,
    input  logic [2:0]            k0_cca,
    input  logic                  tlbwi,
    input  logic                  tlbwr,
    input  logic                  tlbp,
    input  logic                  tlbr,
    input  logic [IDX_W-1:0]      tlb_index,
    input  logic [IDX_W-1:0]      wired,
    input  logic [19+ASID_W-1:0]  entryhi_in,
    input  logic [26:0]           entrylo0_in,
    input  logic [26:0]           entrylo1_in,
    output logic                  probe_hit,
    output logic [IDX_W-1:0]      probe_idx,
    output logic [19+ASID_W-1:0]  rd_entryhi,
    output logic [26:0]           rd_entrylo0,
    output logic [26:0]           rd_entrylo1,
    output logic [IDX_W-1:0]      random_idx
);

    localparam int               HI_W     = 19 + ASID_W;
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef struct packed {
        logic [18:0]       vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [19:0]       pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [19:0]       pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        modified;
    } xlate_t;

    tlb_entry_t tlb_q [TLB_ENTRIES];
    tlb_entry_t tlb_d [TLB_ENTRIES];

    logic             inst_rvalid_q, inst_rvalid_d;
    logic [31:0]      inst_paddr_q, inst_paddr_d;
    logic             inst_uncached_q, inst_uncached_d;
    logic             inst_refill_q, inst_refill_d;
    logic             inst_invalid_q, inst_invalid_d;
    logic             data_rvalid_q, data_rvalid_d;
    logic [31:0]      data_paddr_q, data_paddr_d;
    logic             no_dcache_q, no_dcache_d;
    logic             data_refill_q, data_refill_d;
    logic             data_invalid_q, data_invalid_d;
    logic             data_modified_q, data_modified_d;
    logic             probe_hit_q, probe_hit_d;
    logic [IDX_W-1:0] probe_idx_q, probe_idx_d;
    logic [HI_W-1:0]  rd_entryhi_q, rd_entryhi_d;
    logic [26:0]      rd_entrylo0_q, rd_entrylo0_d;
    logic [26:0]      rd_entrylo1_q, rd_entrylo1_d;
    logic [IDX_W-1:0] random_q, random_d;

    tlb_entry_t       new_entry;
    logic [IDX_W-1:0] wr_idx;
    xlate_t           inst_res;
    xlate_t           data_res;
    logic             lo_unused;
    logic             inst_mod_unused;

    // EntryLo is {PFN,C,D,V,G} right-aligned in 27 bits; the top bit carries nothing.
    assign lo_unused       = entrylo0_in[26] ^ entrylo1_in[26];
    assign inst_mod_unused = inst_res.modified;

`ifndef MMU_K0_CFG_EN
    logic k0_unused;
    assign k0_unused = ^k0_cca;
`endif

    function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                         input logic [ASID_W-1:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    function automatic xlate_t translate(input logic [31:0] va, input logic is_store,
                                         input logic [ASID_W-1:0] asid);
        xlate_t      r;
        tlb_entry_t  e;
        logic        hit;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        r   = '0;
        e   = '0;
        hit = 1'b0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entry_match(tlb_q[i], va[31:13], asid)) begin
                hit = 1'b1;
                e   = tlb_q[i];
            end
        end
        pfn = va[12] ? e.pfn1 : e.pfn0;
        c   = va[12] ? e.c1   : e.c0;
        d   = va[12] ? e.d1   : e.d0;
        v   = va[12] ? e.v1   : e.v0;
        if (va[31:30] == 2'b10) begin
            r.paddr = {3'b000, va[28:0]};
            if (va[29]) begin
                r.uncached = 1'b1;
            end else begin
`ifdef MMU_K0_CFG_EN
                r.uncached = (k0_cca != 3'd3);
`else
                r.uncached = 1'b0;
`endif
            end
        end else if (!hit) begin
            r.refill = 1'b1;
        end else if (!v) begin
            r.invalid = 1'b1;
        end else if (is_store && !d) begin
            r.modified = 1'b1;
        end else begin
            r.paddr    = {pfn, va[11:0]};
            r.uncached = (c != 3'd3);
        end
        return r;
    endfunction

    always_comb begin
        new_entry.vpn2 = entryhi_in[HI_W-1:ASID_W];
        new_entry.asid = entryhi_in[ASID_W-1:0];
        new_entry.g    = entrylo0_in[0] & entrylo1_in[0];
        new_entry.pfn0 = entrylo0_in[25:6];
        new_entry.c0   = entrylo0_in[5:3];
        new_entry.d0   = entrylo0_in[2];
        new_entry.v0   = entrylo0_in[1];
        new_entry.pfn1 = entrylo1_in[25:6];
        new_entry.c1   = entrylo1_in[5:3];
        new_entry.d1   = entrylo1_in[2];
        new_entry.v1   = entrylo1_in[1];
        wr_idx = tlbwi ? tlb_index : random_q;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            tlb_d[i] = tlb_q[i];
        end
        if (tlbwi || tlbwr) begin
            tlb_d[wr_idx] = new_entry;
        end
    end

    always_comb begin
        inst_res        = translate(inst_vaddr, 1'b0, cp0_asid);
        inst_rvalid_d   = inst_req;
        inst_paddr_d    = inst_req ? inst_res.paddr    : inst_paddr_q;
        inst_uncached_d = inst_req ? inst_res.uncached : inst_uncached_q;
        inst_refill_d   = inst_req ? inst_res.refill   : inst_refill_q;
        inst_invalid_d  = inst_req ? inst_res.invalid  : inst_invalid_q;
    end

    always_comb begin
        data_res        = translate(data_vaddr, data_wr, cp0_asid);
        data_rvalid_d   = data_req;
        data_paddr_d    = data_req ? data_res.paddr    : data_paddr_q;
        no_dcache_d     = data_req ? data_res.uncached : no_dcache_q;
        data_refill_d   = data_req ? data_res.refill   : data_refill_q;
        data_invalid_d  = data_req ? data_res.invalid  : data_invalid_q;
        data_modified_d = data_req ? data_res.modified : data_modified_q;
    end

    always_comb begin
        probe_hit_d = probe_hit_q;
        probe_idx_d = probe_idx_q;
        if (tlbp) begin
            probe_hit_d = 1'b0;
            probe_idx_d = '0;
            for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
                if (entry_match(tlb_q[i], entryhi_in[HI_W-1:ASID_W], entryhi_in[ASID_W-1:0])) begin
                    probe_hit_d = 1'b1;
                    probe_idx_d = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        rd_entryhi_d  = rd_entryhi_q;
        rd_entrylo0_d = rd_entrylo0_q;
        rd_entrylo1_d = rd_entrylo1_q;
        if (tlbr) begin
            rd_entryhi_d  = {tlb_q[tlb_index].vpn2, tlb_q[tlb_index].asid};
            rd_entrylo0_d = {1'b0, tlb_q[tlb_index].pfn0, tlb_q[tlb_index].c0,
                             tlb_q[tlb_index].d0, tlb_q[tlb_index].v0, tlb_q[tlb_index].g};
            rd_entrylo1_d = {1'b0, tlb_q[tlb_index].pfn1, tlb_q[tlb_index].c1,
                             tlb_q[tlb_index].d1, tlb_q[tlb_index].v1, tlb_q[tlb_index].g};
        end
    end

    // Wired >= top also lands here every cycle, pinning Random at the top entry.
    always_comb begin
        if (tlbwr || (random_q <= wired)) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_q[i] <= '0;
            end
            inst_rvalid_q   <= 1'b0;
            inst_paddr_q    <= '0;
            inst_uncached_q <= 1'b0;
            inst_refill_q   <= 1'b0;
            inst_invalid_q  <= 1'b0;
            data_rvalid_q   <= 1'b0;
            data_paddr_q    <= '0;
            no_dcache_q     <= 1'b0;
            data_refill_q   <= 1'b0;
            data_invalid_q  <= 1'b0;
            data_modified_q <= 1'b0;
            probe_hit_q     <= 1'b0;
            probe_idx_q     <= '0;
            rd_entryhi_q    <= '0;
            rd_entrylo0_q   <= '0;
            rd_entrylo1_q   <= '0;
            random_q        <= RAND_TOP;
        end else begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_q[i] <= tlb_d[i];
            end
            inst_rvalid_q   <= inst_rvalid_d;
            inst_paddr_q    <= inst_paddr_d;
            inst_uncached_q <= inst_uncached_d;
            inst_refill_q   <= inst_refill_d;
            inst_invalid_q  <= inst_invalid_d;
            data_rvalid_q   <= data_rvalid_d;
            data_paddr_q    <= data_paddr_d;
            no_dcache_q     <= no_dcache_d;
            data_refill_q   <= data_refill_d;
            data_invalid_q  <= data_invalid_d;
            data_modified_q <= data_modified_d;
            probe_hit_q     <= probe_hit_d;
            probe_idx_q     <= probe_idx_d;
            rd_entryhi_q    <= rd_entryhi_d;
            rd_entrylo0_q   <= rd_entrylo0_d;
            rd_entrylo1_q   <= rd_entrylo1_d;
            random_q        <= random_d;
        end
    end

    assign inst_rvalid   = inst_rvalid_q;
    assign inst_paddr    = inst_paddr_q;
    assign inst_uncached = inst_uncached_q;
    assign inst_refill   = inst_refill_q;
    assign inst_invalid  = inst_invalid_q;
    assign data_rvalid   = data_rvalid_q;
    assign data_paddr    = data_paddr_q;
    assign no_dcache     = no_dcache_q;
    assign data_refill   = data_refill_q;
    assign data_invalid  = data_invalid_q;
    assign data_modified = data_modified_q;
    assign probe_hit     = probe_hit_q;
    assign probe_idx     = probe_idx_q;
    assign rd_entryhi    = rd_entryhi_q;
    assign rd_entrylo0   = rd_entrylo0_q;
    assign rd_entrylo1   = rd_entrylo1_q;
    assign random_idx    = random_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: unmapped segments, TLB hit/fault paths, CP0 ops and Random.
module tb_mmu_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic        inst_rvalid;
    logic [31:0] inst_paddr;
    logic        inst_uncached, inst_refill, inst_invalid;
    logic        data_req, data_wr;
    logic [31:0] data_vaddr;
    logic        data_rvalid;
    logic [31:0] data_paddr;
    logic        no_dcache, data_refill, data_invalid, data_modified;
    logic [7:0]  cp0_asid;
    logic [2:0]  k0_cca;
    logic        tlbwi, tlbwr, tlbp, tlbr;
    logic [3:0]  tlb_index, wired;
    logic [26:0] entryhi_in, entrylo0_in, entrylo1_in;
    logic        probe_hit;
    logic [3:0]  probe_idx;
    logic [26:0] rd_entryhi, rd_entrylo0, rd_entrylo1;
    logic [3:0]  random_idx;

    int nvec = 0;
    int nmis = 0;
    bit found;

`ifdef MMU_K0_CFG_EN
    localparam logic K0_UNC_CCA2 = 1'b1;
`else
    localparam logic K0_UNC_CCA2 = 1'b0;
`endif

    mmu_tlb dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_rvalid(inst_rvalid),
        .inst_paddr(inst_paddr), .inst_uncached(inst_uncached), .inst_refill(inst_refill),
        .inst_invalid(inst_invalid),
        .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr), .data_rvalid(data_rvalid),
        .data_paddr(data_paddr), .no_dcache(no_dcache), .data_refill(data_refill),
        .data_invalid(data_invalid), .data_modified(data_modified),
        .cp0_asid(cp0_asid), .k0_cca(k0_cca),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
        .tlb_index(tlb_index), .wired(wired),
        .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
        .probe_hit(probe_hit), .probe_idx(probe_idx),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
        .random_idx(random_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {PFN, C, D, V, G} right-aligned in 27 bits.
    function automatic logic [26:0] lo(input logic [19:0] pfn, input logic [2:0] c,
                                       input logic d, input logic v, input logic g);
        return {1'b0, pfn, c, d, v, g};
    endfunction

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_vaddr = 0; data_req = 0; data_wr = 0; data_vaddr = 0;
        cp0_asid = 0; k0_cca = 0; tlbwi = 0; tlbwr = 0; tlbp = 0; tlbr = 0;
        tlb_index = 0; wired = 0; entryhi_in = 0; entrylo0_in = 0; entrylo1_in = 0;
        #3;
        chk("rst_random", random_idx, 4'd15);
        chk("rst_inst_rvalid", inst_rvalid, 1'b0);
        chk("rst_data_rvalid", data_rvalid, 1'b0);
        chk("rst_probe_hit", probe_hit, 1'b0);
        tick();
        rst = 1'b0;

        // kseg1 fetch
        inst_req = 1; inst_vaddr = 32'hBFC0_0000;
        tick();
        inst_req = 0;
        chk("kseg1_rvalid", inst_rvalid, 1'b1);
        chk("kseg1_paddr", inst_paddr, 32'h1FC0_0000);
        chk("kseg1_uncached", inst_uncached, 1'b1);
        chk("kseg1_faults", {inst_refill, inst_invalid}, 2'b00);
        tick();
        chk("idle_rvalid", inst_rvalid, 1'b0);
        chk("idle_hold_paddr", inst_paddr, 32'h1FC0_0000);

        // kseg0 with two K0 settings
        data_req = 1; data_vaddr = 32'h8000_1234; k0_cca = 3'd2;
        tick();
        chk("kseg0_paddr", data_paddr, 32'h0000_1234);
        chk("kseg0_cca2_nodc", no_dcache, K0_UNC_CCA2);
        k0_cca = 3'd3;
        tick();
        chk("kseg0_cca3_nodc", no_dcache, 1'b0);
        chk("kseg0_faults", {data_refill, data_invalid, data_modified}, 3'b000);

        // tlbwi index 3; a lookup in the same cycle still sees the empty TLB
        cp0_asid = 8'd5;
        tlbwi = 1; tlb_index = 4'd3;
        entryhi_in  = {19'h0_0004, 8'd5};
        entrylo0_in = lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b0);
        entrylo1_in = lo(20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        data_vaddr = 32'h0000_8ABC;
        tick();
        tlbwi = 0;
        chk("wr_same_cycle_old", data_refill, 1'b1);
        chk("fault_paddr_zero", data_paddr, 32'h0);
        inst_req = 1; inst_vaddr = 32'h0000_8ABC;
        tick();
        inst_req = 0;
        chk("hit_data_paddr", data_paddr, 32'h1234_5ABC);
        chk("hit_data_flags", {no_dcache, data_refill, data_invalid, data_modified}, 4'b0000);
        chk("hit_inst_paddr", inst_paddr, 32'h1234_5ABC);
        chk("hit_inst_flags", {inst_uncached, inst_refill, inst_invalid}, 3'b000);

        data_vaddr = 32'h0000_9000;
        tick();
        chk("odd_invalid", {data_refill, data_invalid, data_modified}, 3'b010);
        chk("odd_invalid_paddr", data_paddr, 32'h0);

        cp0_asid = 8'd6; data_vaddr = 32'h0000_8ABC;
        tick();
        chk("asid_refill", {data_refill, data_invalid, data_modified}, 3'b100);
        cp0_asid = 8'd5;

        // Rewrite entry 3 with D0=0
        data_req = 0;
        tlbwi = 1;
        entrylo0_in = lo(20'h12345, 3'd3, 1'b0, 1'b1, 1'b0);
        tick();
        tlbwi = 0;
        data_req = 1; data_wr = 1; data_vaddr = 32'h0000_8000;
        tick();
        chk("store_modified", {data_refill, data_invalid, data_modified}, 3'b001);
        chk("store_mod_paddr", data_paddr, 32'h0);
        data_wr = 0;
        tick();
        chk("load_no_fault", {data_refill, data_invalid, data_modified}, 3'b000);
        chk("load_paddr", data_paddr, 32'h1234_5000);
        data_wr = 1; data_vaddr = 32'h0000_9000;
        tick();
        chk("store_invalid_prio", {data_refill, data_invalid, data_modified}, 3'b010);
        data_wr = 0; data_req = 0;

        // Global entry at index 5 (both G set), different ASID
        tlbwi = 1; tlb_index = 4'd5;
        entryhi_in  = {19'h0_0010, 8'd9};
        entrylo0_in = lo(20'hABCDE, 3'd2, 1'b1, 1'b1, 1'b1);
        entrylo1_in = lo(20'h11111, 3'd3, 1'b1, 1'b1, 1'b1);
        tick();
        tlbwi = 0;
        data_req = 1; data_vaddr = 32'h0002_0010;
        tick();
        chk("global_paddr", data_paddr, 32'hABCD_E010);
        chk("global_uncached", no_dcache, 1'b1);
        data_req = 0;

        // Probe hit and miss
        tlbp = 1; entryhi_in = {19'h0_0004, 8'd5};
        tick();
        tlbp = 0;
        chk("probe_hit", probe_hit, 1'b1);
        chk("probe_idx", probe_idx, 4'd3);
        tick();
        chk("probe_held", {probe_hit, probe_idx}, {1'b1, 4'd3});
        tlbp = 1; entryhi_in = {19'h0_0005, 8'd5};
        tick();
        tlbp = 0;
        chk("probe_miss", {probe_hit, probe_idx}, {1'b0, 4'd0});

        // Read back entries 3 and 5
        tlbr = 1; tlb_index = 4'd3;
        tick();
        chk("rd3_hi", rd_entryhi, {19'h0_0004, 8'd5});
        chk("rd3_lo0", rd_entrylo0, lo(20'h12345, 3'd3, 1'b0, 1'b1, 1'b0));
        chk("rd3_lo1", rd_entrylo1, 27'h0);
        tlb_index = 4'd5;
        tick();
        tlbr = 0;
        chk("rd5_lo0", rd_entrylo0, lo(20'hABCDE, 3'd2, 1'b1, 1'b1, 1'b1));
        chk("rd5_lo1", rd_entrylo1, lo(20'h11111, 3'd3, 1'b1, 1'b1, 1'b1));

        // Random with wired=12
        wired = 4'd12;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (random_idx == 4'd15) found = 1;
        end
        chk("random_reach_top", found, 1'b1);
        tick();
        chk("random_14", random_idx, 4'd14);
        tick();
        chk("random_13", random_idx, 4'd13);
        tick();
        chk("random_12", random_idx, 4'd12);
        tick();
        chk("random_reload", random_idx, 4'd15);
        tick();
        chk("random_pre_wr", random_idx, 4'd14);

        // tlbwr lands at 14, Random reloads
        tlbwr = 1;
        entryhi_in  = {19'h0_0030, 8'd5};
        entrylo0_in = lo(20'h0BEEF, 3'd3, 1'b1, 1'b1, 1'b0);
        entrylo1_in = lo(20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tlbwr = 0;
        chk("random_after_wr", random_idx, 4'd15);
        data_req = 1; data_vaddr = 32'h0006_0000;
        tlbr = 1; tlb_index = 4'd14;
        tick();
        tlbr = 0;
        chk("tlbwr_hit_paddr", data_paddr, 32'h0BEE_F000);
        chk("tlbwr_hit_flags", {data_refill, data_invalid}, 2'b00);
        chk("tlbwr_rd14_hi", rd_entryhi, {19'h0_0030, 8'd5});

        // Asynchronous reset with a request in flight
        data_vaddr = 32'h8000_0000;
        tick();
        chk("pre_rst_rvalid", data_rvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rvalid", data_rvalid, 1'b0);
        chk("async_rst_random", random_idx, 4'd15);
        chk("async_rst_rd", rd_entryhi, 27'h0);
        tick();
        rst = 1'b0;
        data_vaddr = 32'h0000_8ABC;
        tick();
        chk("rst_clears_tlb", data_refill, 1'b1);
        data_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Next-generation address translation unit for the MIPS core. Translates the instruction-fetch and data-access channels in parallel.
- kseg0/kseg1 keep the fixed unmapped translation. kuseg, kseg2 and kseg3 go through a parametrised fully-associative TLB with ASID matching and page faults.
- Provides the CP0 TLB-maintenance operations: indexed write, random write, probe and read.
- Sits between the fetch/memory stages and the cache/bus interface. Results are registered with 1-cycle latency.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of two, 4..32)
IDX_W, 4, index width, equal to log2(TLB_ENTRIES)
ASID_W, 8, address-space identifier width

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
inst_req  in  1  instruction translation request
inst_vaddr  in  32  instruction virtual address
inst_rvalid  out  1  instruction result valid (1 cycle after inst_req)
inst_paddr  out  32  instruction physical address
inst_uncached  out  1  instruction access bypasses the cache
inst_refill  out  1  instruction TLB miss
inst_invalid  out  1  instruction hit on a page with V=0
data_req  in  1  data translation request
data_wr  in  1  request is a store
data_vaddr  in  32  data virtual address
data_rvalid  out  1  data result valid
data_paddr  out  32  data physical address
no_dcache  out  1  data access bypasses the D-cache
data_refill  out  1  data TLB miss
data_invalid  out  1  data hit on a page with V=0
data_modified  out  1  store to a valid page with D=0
cp0_asid  in  ASID_W  current ASID
k0_cca  in  3  Config.K0 cacheability field
tlbwi  in  1  write the entry at tlb_index
tlbwr  in  1  write the entry at random_idx
tlbp  in  1  probe
tlbr  in  1  read the entry at tlb_index
tlb_index  in  IDX_W  index for tlbwi and tlbr
wired  in  IDX_W  CP0 Wired value
entryhi_in  in  19+ASID_W  {VPN2[31:13], ASID}
entrylo0_in  in  27  {PFN[19:0], C[2:0], D, V, G} for the even page
entrylo1_in  in  27  same format, odd page
probe_hit  out  1  probe matched an entry
probe_idx  out  IDX_W  matching index
rd_entryhi  out  19+ASID_W  entry read by tlbr
rd_entrylo0  out  27  entry read by tlbr; G reported as the entry's global bit
rd_entrylo1  out  27  entry read by tlbr; same G rule
random_idx  out  IDX_W  current Random value

Behaviour:
- Reset, while rst is high and asynchronously:
  - every entry is cleared (V0=V1=D0=D1=G=0);
  - all outputs are 0 except random_idx, which is TLB_ENTRIES-1.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr={3'b0,vaddr[28:0]}. Uncached when k0_cca!=3 (see the optional feature).
  - 101 (kseg1): paddr={3'b0,vaddr[28:0]}, always uncached.
  - Unmapped segments never raise faults.
  - All other values are mapped.
- Mapped lookup:
  - An entry matches when VPN2==vaddr[31:13] and (G or ASID==cp0_asid).
  - vaddr[12] selects the odd or even half.
  - On a hit: paddr={PFN,vaddr[11:0]}, and uncached = (C!=3).
  - If several entries match, the lowest index wins.
- Fault priority: refill > invalid > modified. At most one fault flag is high at a time.
  - On a fault, paddr=0 and uncached=0.
  - modified applies to the data channel only: data_wr=1, V=1, D=0.
- Latency and channels:
  - A request sampled in cycle N gives its result and xx_rvalid=1 in cycle N+1.
  - With no request, xx_rvalid=0 and the other outputs hold their last values.
  - The two channels are fully independent and may both request in the same cycle.
- Writes:
  - tlbwi or tlbwr updates the entry at the clock edge. G is stored as entrylo0_in.G AND entrylo1_in.G.
  - A lookup or probe in the same cycle as a write sees the old contents. The next cycle sees the new contents.
  - tlbwi and tlbwr asserted together: tlbwi wins.
- Probe: tlbp matches against entryhi_in.
  - probe_hit and probe_idx are registered and valid the cycle after tlbp, then held until the next tlbp.
  - On a miss, probe_idx=0.
- Read: rd_entry* are registered the cycle after tlbr and held until the next tlbr.
- Random counter:
  - Decrements each cycle.
  - When it is at or below wired, it reloads TLB_ENTRIES-1 on the next edge.
  - After tlbwr, it also reloads TLB_ENTRIES-1.
  - If wired > TLB_ENTRIES-1, random_idx stays at TLB_ENTRIES-1.
- Reset mid-operation discards any pending result: rvalid goes to 0 immediately.

Optional Feature:
- Macro: MMU_K0_CFG_EN.
- Defined: kseg0 cacheability follows k0_cca (cached only when k0_cca==3).
- Undefined: k0_cca is ignored and kseg0 is always cached.
- kseg1 and mapped behaviour are the same in both builds.

Test Plan:
- Reset, then inst_req with inst_vaddr=0xBFC00000 -> next cycle inst_rvalid=1, inst_paddr=0x1FC00000, inst_uncached=1, no faults.
- data_req with data_vaddr=0x80001234, with k0_cca=2 and then k0_cca=3 -> data_paddr=0x00001234. With MMU_K0_CFG_EN: no_dcache=1 then 0. Without it: 0 both times.
- tlbwi index 3 with entryhi={0x00004,ASID 5}, lo0 PFN=0x12345 C=3 D=1 V=1, lo1 V=0; cp0_asid=5.
  - Access 0x00008ABC -> paddr=0x12345ABC.
  - Access 0x00009000 -> invalid=1.
  - Access with cp0_asid=6 -> refill=1.
- Same entry with D0=0; data_wr=1 at 0x00008000 -> data_modified=1; the same load -> no fault.
- tlbp with a matching entryhi -> probe_hit=1, probe_idx=3. tlbr index 3 -> rd_* equals the written values.
- wired=12: observe random_idx 15, 14, 13, 12, 15. tlbwr writes at the current random_idx, and the next cycle's lookup hits.
